// File: rtl/rtc_scan_display.sv
// Time-multiplexed 7-segment driver for the six RTC BCD digits, with a frame snapshot and leading-zero blanking.
// Optional colon blink on dp: define RTC_SCAN_COLON_BLINK_EN.
module rtc_scan_display #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLANK_CYC      = 4,
    parameter int unsigned LZ_SUPPRESS    = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sl,
    input  logic [3:0] sm,
    input  logic [3:0] ml,
    input  logic [3:0] mm,
    input  logic [3:0] hl,
    input  logic [3:0] hm,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig_en,
    output logic       frame_start
);

    localparam int unsigned   CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [6:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic          DP_OFF    = (SEG_ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        SLOT_SL = 3'd0,
        SLOT_SM = 3'd1,
        SLOT_ML = 3'd2,
        SLOT_MM = 3'd3,
        SLOT_HL = 3'd4,
        SLOT_HM = 3'd5
    } slot_t;

    slot_t         idx, idx_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          slot_end;
    logic          frame_end;

    logic [3:0] sh_sl, sh_sm, sh_ml, sh_mm, sh_hl, sh_hm;

    logic [3:0] cur_digit;
    logic [6:0] seg_raw;
    logic       dp_raw;
    logic [6:0] seg_next;
    logic       dp_next;
    logic [5:0] dig_en_next;

    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == SLOT_HM);
        cnt_next  = slot_end ? '0 : cnt + 1'b1;
    end

    always_comb begin
        idx_next = idx;
        if (slot_end) begin
            unique case (idx)
                SLOT_SL: idx_next = SLOT_SM;
                SLOT_SM: idx_next = SLOT_ML;
                SLOT_ML: idx_next = SLOT_MM;
                SLOT_MM: idx_next = SLOT_HL;
                SLOT_HL: idx_next = SLOT_HM;
                SLOT_HM: idx_next = SLOT_SL;
                default: idx_next = SLOT_SL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= SLOT_SL;
        end else begin
            cnt <= cnt_next;
            idx <= idx_next;
        end
    end

    // Inputs are only sampled at the frame boundary so a frame never mixes two times.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_sl <= '0;
            sh_sm <= '0;
            sh_ml <= '0;
            sh_mm <= '0;
            sh_hl <= '0;
            sh_hm <= '0;
        end else if (frame_end) begin
            sh_sl <= sl;
            sh_sm <= sm;
            sh_ml <= ml;
            sh_mm <= mm;
            sh_hl <= hl;
            sh_hm <= hm;
        end
    end

    always_comb begin
        cur_digit = '0;
        unique case (idx)
            SLOT_SL: cur_digit = sh_sl;
            SLOT_SM: cur_digit = sh_sm;
            SLOT_ML: cur_digit = sh_ml;
            SLOT_MM: cur_digit = sh_mm;
            SLOT_HL: cur_digit = sh_hl;
            SLOT_HM: cur_digit = sh_hm;
            default: cur_digit = '0;
        endcase
    end

    always_comb begin
        seg_raw = '0;
        case (cur_digit)
            4'd0:    seg_raw = 7'h7E;
            4'd1:    seg_raw = 7'h30;
            4'd2:    seg_raw = 7'h6D;
            4'd3:    seg_raw = 7'h79;
            4'd4:    seg_raw = 7'h33;
            4'd5:    seg_raw = 7'h5B;
            4'd6:    seg_raw = 7'h5F;
            4'd7:    seg_raw = 7'h70;
            4'd8:    seg_raw = 7'h7F;
            4'd9:    seg_raw = 7'h7B;
            default: seg_raw = 7'h00;
        endcase
        if ((LZ_SUPPRESS != 0) && (idx == SLOT_HM) && (sh_hm == 4'd0)) begin
            seg_raw = '0;
        end
    end

    always_comb begin
`ifdef RTC_SCAN_COLON_BLINK_EN
        dp_raw = ((idx == SLOT_ML) || (idx == SLOT_HL)) && !sh_sl[0];
`else
        dp_raw = 1'b0;
`endif
        seg_next    = seg_raw ^ SEG_OFF;
        dp_next     = dp_raw ^ DP_OFF;
        dig_en_next = (cnt >= CNT_BLANK) ? (6'b000001 << idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg         <= SEG_OFF;
            dp          <= 1'b0;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_next;
            dp          <= dp_next;
            dig_en      <= dig_en_next;
            frame_start <= frame_end;
        end
    end

endmodule

// File: tb/tb_rtc_scan_display.sv
// Randomised and directed bench for rtc_scan_display against a frame/slot arithmetic model.
module tb_rtc_scan_display;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = 6 * SD;

    typedef struct packed {
        logic [6:0] seg;
        logic [6:0] seg_n;
        logic       dp;
        logic [5:0] en;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d [6];
    logic [6:0] seg, seg_n;
    logic       dp, dp_n, fs, fs_n;
    logic [5:0] en, en_n;

    int errors = 0;
    int checks = 0;

    // Model: k = clock edges since reset release; disp = digits visible to outputs.
    int         k = 0;
    logic [3:0] disp [6];
    logic [3:0] pend [6];
    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    exp_t e;

    rtc_scan_display #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_SUPPRESS(1), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .sl(d[0]), .sm(d[1]), .ml(d[2]), .mm(d[3]), .hl(d[4]), .hm(d[5]),
        .seg(seg), .dp(dp), .dig_en(en), .frame_start(fs)
    );

    rtc_scan_display #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_SUPPRESS(0), .SEG_ACTIVE_LOW(0)) dut_nlz (
        .clk(clk), .rst(rst), .sl(d[0]), .sm(d[1]), .ml(d[2]), .mm(d[3]), .hl(d[4]), .hm(d[5]),
        .seg(seg_n), .dp(dp_n), .dig_en(en_n), .frame_start(fs_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0;
            for (int i = 0; i < 6; i++) begin
                disp[i] = 4'd0;
                pend[i] = 4'd0;
            end
        end else begin
            k = k + 1;
            if (k % FR == 1 && k > 1) disp = pend;
            if (k % FR == 0) pend = d;
        end
    end

    function automatic exp_t expect_at(int kk);
        exp_t r;
        int   p, slot, c;
        r = '0;
        if (kk == 0) return r;
        p    = (kk - 1) % FR;
        slot = p / SD;
        c    = p % SD;
        r.seg   = seg_tab[disp[slot]];
        r.seg_n = r.seg;
        if (slot == 5 && disp[5] == 4'd0) r.seg = 7'h00;
        if (c >= BC) r.en = 6'(1 << slot);
`ifdef RTC_SCAN_COLON_BLINK_EN
        r.dp = (slot == 2 || slot == 4) && (disp[0][0] == 1'b0);
`endif
        r.fs = (kk % FR == 0);
        return r;
    endfunction

    task automatic test_reset();
        int first_fs;
        #1;
        checks++;
        if ({seg, dp, en, fs, seg_n, en_n} !== '0) begin
            errors++;
            $display("FAIL reset_init seg=%h dp=%b en=%b fs=%b required all zero", seg, dp, en, fs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            e = expect_at(k);
            checks++;
            if ({seg, dp, en, fs} !== {e.seg, e.dp, e.en, e.fs} || !$onehot0(en)) begin
                errors++;
                $display("FAIL pre_reset k=%0d got seg=%h dp=%b en=%b fs=%b want seg=%h dp=%b en=%b fs=%b",
                         k, seg, dp, en, fs, e.seg, e.dp, e.en, e.fs);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({seg, dp, en, fs, seg_n, en_n} !== '0) begin
            errors++;
            $display("FAIL reset_async seg=%h dp=%b en=%b fs=%b required all zero", seg, dp, en, fs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        first_fs = -1;
        repeat (FR + 10) begin
            @(negedge clk);
            e = expect_at(k);
            if (fs === 1'b1 && first_fs < 0) first_fs = k;
            checks++;
            if ({seg, dp, en, fs} !== {e.seg, e.dp, e.en, e.fs} || !$onehot0(en)) begin
                errors++;
                $display("FAIL post_reset k=%0d got seg=%h dp=%b en=%b fs=%b want seg=%h dp=%b en=%b fs=%b",
                         k, seg, dp, en, fs, e.seg, e.dp, e.en, e.fs);
            end
        end
        checks++;
        if (first_fs !== FR) begin
            errors++;
            $display("FAIL first_frame_start got cycle %0d required %0d", first_fs, FR);
        end
    endtask

    task automatic test_scan_order();
        d = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        repeat (3 * FR) begin
            @(negedge clk);
            e = expect_at(k);
            checks++;
            if ({seg, dp, en, fs, seg_n} !== {e.seg, e.dp, e.en, e.fs, e.seg_n} || !$onehot0(en)) begin
                errors++;
                $display("FAIL scan_order k=%0d got seg=%h dp=%b en=%b fs=%b want seg=%h dp=%b en=%b fs=%b",
                         k, seg, dp, en, fs, e.seg, e.dp, e.en, e.fs);
            end
        end
    endtask

    task automatic test_leading_zero();
        d[5] = 4'd0;
        d[4] = 4'd9;
        repeat (3 * FR) begin
            @(negedge clk);
            e = expect_at(k);
            checks++;
            if ({seg, en, seg_n, en_n} !== {e.seg, e.en, e.seg_n, e.en}) begin
                errors++;
                $display("FAIL leading_zero k=%0d got seg=%h seg_nlz=%h en=%b want seg=%h seg_nlz=%h en=%b",
                         k, seg, seg_n, en, e.seg, e.seg_n, e.en);
            end
        end
    endtask

    task automatic test_invalid_bcd();
        d[2] = 4'hC;
        repeat (3 * FR) begin
            @(negedge clk);
            e = expect_at(k);
            checks++;
            if ({seg, dp, en, fs, seg_n} !== {e.seg, e.dp, e.en, e.fs, e.seg_n}) begin
                errors++;
                $display("FAIL invalid_bcd k=%0d got seg=%h en=%b want seg=%h en=%b", k, seg, en, e.seg, e.en);
            end
        end
    endtask

    task automatic test_snapshot();
        bit changed;
        d = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        changed = 1'b0;
        repeat (4 * FR) begin
            @(negedge clk);
            e = expect_at(k);
            checks++;
            if ({seg, dp, en, fs} !== {e.seg, e.dp, e.en, e.fs}) begin
                errors++;
                $display("FAIL snapshot k=%0d got seg=%h en=%b fs=%b want seg=%h en=%b fs=%b",
                         k, seg, en, fs, e.seg, e.en, e.fs);
            end
            if (!changed && disp[0] == 4'd6 && ((k - 1) % FR) / SD == 3) begin
                d[0] = 4'd7;
                changed = 1'b1;
            end
        end
    endtask

    task automatic test_colon_blink();
        d[0] = 4'd4;
        repeat (5 * FR) begin
            @(negedge clk);
            e = expect_at(k);
            checks++;
            if ({seg, dp, en, dp_n} !== {e.seg, e.dp, e.en, e.dp}) begin
                errors++;
                $display("FAIL colon_blink k=%0d got dp=%b dp_nlz=%b seg=%h want dp=%b seg=%h",
                         k, dp, dp_n, seg, e.dp, e.seg);
            end
            if (k % FR == 20) d[0] = (d[0] == 4'd4) ? 4'd5 : 4'd4;
        end
    endtask

    task automatic test_random();
        repeat (8 * FR) begin
            @(negedge clk);
            e = expect_at(k);
            checks++;
            if ({seg, dp, en, fs, seg_n, dp_n, en_n, fs_n} !==
                {e.seg, e.dp, e.en, e.fs, e.seg_n, e.dp, e.en, e.fs} || !$onehot0(en)) begin
                errors++;
                $display("FAIL random k=%0d got seg=%h seg_nlz=%h dp=%b en=%b fs=%b want seg=%h seg_nlz=%h dp=%b en=%b fs=%b",
                         k, seg, seg_n, dp, en, fs, e.seg, e.seg_n, e.dp, e.en, e.fs);
            end
            if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) d[i] = 4'd0;
        test_reset();
        test_scan_order();
        test_leading_zero();
        test_invalid_bcd();
        test_snapshot();
        test_colon_blink();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
